// File: rtl/slave_rx_if.sv
// Valid/ready word channel between the master stage and slave_rx.
interface slave_rx_if;
  logic       vaild;
  logic [7:0] master_data;
  logic       ready;

  modport master (output vaild, output master_data, input ready);
  modport slave  (input vaild, input master_data, output ready);
endinterface

// File: rtl/slave_rx.sv
// Slow-consumer receiver: FIFO-buffered accept, rate-limited drain, optional
// sequence checker enabled by defining SLAVE_SEQ_CHECK_EN.
module slave_rx #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL        = 6,
  parameter int unsigned DRAIN_PERIOD = 3
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  slave_rx_if.slave                bus,
  output logic [7:0]               rx_data,
  output logic                     rx_vld,
  output logic [15:0]              rx_cnt,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     seq_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [DW-1:0] dcnt;
  logic          tick, push, pop;
  logic [CW-1:0] cnt_next;

  assign tick = (dcnt == DW'(DRAIN_PERIOD - 1));
  assign push = bus.vaild && bus.ready;
  assign pop  = tick && (fifo_cnt != '0);

  always_comb begin
    cnt_next = fifo_cnt;
    case ({push, pop})
      2'b10:   cnt_next = fifo_cnt + CW'(1);
      2'b01:   cnt_next = fifo_cnt - CW'(1);
      default: cnt_next = fifo_cnt;
    endcase
  end

  // Storage needs no reset: pointer reset alone discards stale entries.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wptr] <= bus.master_data;
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      dcnt      <= '0;
      fifo_cnt  <= '0;
      bus.ready <= 1'b0;
      rx_data   <= '0;
      rx_vld    <= 1'b0;
      rx_cnt    <= '0;
    end else begin
      dcnt      <= tick ? '0 : dcnt + DW'(1);
      fifo_cnt  <= cnt_next;
      bus.ready <= (cnt_next < CW'(AFULL));
      rx_vld    <= pop;
      if (push) begin
        wptr   <= wptr + AW'(1);
        rx_cnt <= rx_cnt + 16'd1;
      end
      if (pop) begin
        rx_data <= mem[rptr];
        rptr    <= rptr + AW'(1);
      end
    end
  end

`ifdef SLAVE_SEQ_CHECK_EN
  logic       seq_init;
  logic [7:0] seq_exp;

  // Master sequence skips 0 and 1 when it wraps.
  function automatic logic [7:0] next_seq(input logic [7:0] v);
    return (v == 8'd255) ? 8'd2 : v + 8'd1;
  endfunction

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      seq_init <= 1'b0;
      seq_exp  <= '0;
      seq_err  <= 1'b0;
    end else if (push) begin
      seq_init <= 1'b1;
      seq_exp  <= next_seq(bus.master_data);
      if (seq_init && (bus.master_data != seq_exp)) seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_slave_rx.sv
// Directed bench for slave_rx: one instance draining every cycle, one every third.
module tb_slave_rx;
  logic sys_clk = 1'b0;
  logic reset;
  always #5 sys_clk = ~sys_clk;

  slave_rx_if bus_a ();
  slave_rx_if bus_b ();

  logic [7:0]  a_rx_data, b_rx_data;
  logic        a_rx_vld, b_rx_vld, a_seq_err, b_seq_err;
  logic [15:0] a_rx_cnt, b_rx_cnt;
  logic [3:0]  a_fifo_cnt, b_fifo_cnt;

  slave_rx #(.DEPTH(8), .AFULL(6), .DRAIN_PERIOD(1)) dut_a (
    .sys_clk(sys_clk), .reset(reset), .bus(bus_a), .rx_data(a_rx_data), .rx_vld(a_rx_vld),
    .rx_cnt(a_rx_cnt), .fifo_cnt(a_fifo_cnt), .seq_err(a_seq_err));

  slave_rx #(.DEPTH(8), .AFULL(6), .DRAIN_PERIOD(3)) dut_b (
    .sys_clk(sys_clk), .reset(reset), .bus(bus_b), .rx_data(b_rx_data), .rx_vld(b_rx_vld),
    .rx_cnt(b_rx_cnt), .fifo_cnt(b_fifo_cnt), .seq_err(b_seq_err));

`ifdef SLAVE_SEQ_CHECK_EN
  localparam logic SEQ_ON = 1'b1;
`else
  localparam logic SEQ_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus_a.vaild = 1'b0;
    bus_b.vaild = 1'b0;
    @(negedge sys_clk);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset = 1'b1;
  endtask

  task automatic send_a(input logic [7:0] w);
    int to;
    to = 0;
    bus_a.vaild       = 1'b1;
    bus_a.master_data = w;
    while (!bus_a.ready && to < 20) begin
      @(negedge sys_clk);
      to++;
    end
    check("send_a_ready", bus_a.ready, 1);
    @(posedge sys_clk);
    #1;
    bus_a.vaild = 1'b0;
  endtask

  initial begin
    logic       acc;
    logic [7:0] d, exp_rx;
    int         pushes, pops;

    reset = 1'b0;
    bus_a.vaild = 1'b0; bus_a.master_data = '0;
    bus_b.vaild = 1'b0; bus_b.master_data = '0;
    repeat (3) @(negedge sys_clk);
    check("rst_a_ready", bus_a.ready, 0);
    check("rst_a_rx_data", a_rx_data, 0);
    check("rst_a_rx_vld", a_rx_vld, 0);
    check("rst_a_rx_cnt", a_rx_cnt, 0);
    check("rst_a_fifo_cnt", a_fifo_cnt, 0);
    check("rst_a_seq_err", a_seq_err, 0);
    check("rst_b_ready", bus_b.ready, 0);
    check("rst_b_fifo_cnt", b_fifo_cnt, 0);
    reset = 1'b1;
    check("t1_first_cycle_ready", bus_a.ready, 0);

    // Test 1: drain every cycle, continuous valid from 2 upward
    d = 8'd2;
    bus_a.vaild = 1'b1;
    bus_a.master_data = d;
    for (int n = 1; n <= 8; n++) begin
      acc = bus_a.vaild && bus_a.ready;
      @(posedge sys_clk);
      #1;
      if (acc) begin
        d++;
        bus_a.master_data = d;
      end
      check("t1_ready", bus_a.ready, 1);
      check("t1_seq_err", a_seq_err, 0);
      if (n >= 2) begin
        check("t1_rx_cnt", a_rx_cnt, n - 1);
        check("t1_fifo_cnt", a_fifo_cnt, 1);
      end
      if (n >= 3) begin
        check("t1_rx_data", a_rx_data, n - 1);
        check("t1_rx_vld", a_rx_vld, 1);
      end
    end
    bus_a.vaild = 1'b0;

    // Test 2: drain every third cycle, continuous valid from 10 upward
    do_reset();
    d = 8'd10;
    exp_rx = 8'd10;
    pushes = 0;
    pops = 0;
    bus_b.vaild = 1'b1;
    bus_b.master_data = d;
    for (int n = 1; n <= 30; n++) begin
      acc = bus_b.vaild && bus_b.ready;
      @(posedge sys_clk);
      #1;
      if (acc) begin
        d++;
        bus_b.master_data = d;
        pushes++;
      end
      if (b_rx_vld) begin
        check("t2_order", b_rx_data, exp_rx);
        exp_rx++;
        pops++;
      end
      check("t2_fifo_le6", b_fifo_cnt <= 4'd6, 1);
      if (n == 6) begin
        check("t2_pushpop_fifo", b_fifo_cnt, 3);
        check("t2_pushpop_oldest", b_rx_data, 11);
      end
      if (n == 10) begin
        check("t2_full_fifo", b_fifo_cnt, 6);
        check("t2_full_ready", bus_b.ready, 0);
      end
      if (n == 12) begin
        check("t2_pop_fifo", b_fifo_cnt, 5);
        check("t2_pop_ready", bus_b.ready, 1);
      end
      if (n == 13) begin
        check("t2_refill_fifo", b_fifo_cnt, 6);
        check("t2_refill_ready", bus_b.ready, 0);
      end
    end
    bus_b.vaild = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge sys_clk);
      #1;
      if (b_rx_vld) begin
        check("t2_order", b_rx_data, exp_rx);
        exp_rx++;
        pops++;
      end
    end
    check("t2_rx_cnt", b_rx_cnt, 15);
    check("t2_pops", pops, 15);
    check("t2_drained", b_fifo_cnt, 0);

    // Test 3: sequence across the 255 -> 2 wrap
    do_reset();
    send_a(8'd253); check("t3_seq_253", a_seq_err, 0);
    send_a(8'd254); check("t3_seq_254", a_seq_err, 0);
    send_a(8'd255); check("t3_seq_255", a_seq_err, 0);
    send_a(8'd2);   check("t3_seq_2", a_seq_err, 0);
    send_a(8'd3);   check("t3_seq_3", a_seq_err, 0);

    // Test 4: skipped word sets the sticky flag
    do_reset();
    send_a(8'd5); check("t4_seq_5", a_seq_err, 0);
    send_a(8'd6); check("t4_seq_6", a_seq_err, 0);
    send_a(8'd8); check("t4_seq_8", a_seq_err, SEQ_ON);
    send_a(8'd9); check("t4_seq_9", a_seq_err, SEQ_ON);

    // Test 5: asynchronous reset with a full FIFO
    do_reset();
    d = 8'd40;
    bus_b.vaild = 1'b1;
    bus_b.master_data = d;
    for (int n = 0; n < 30; n++) begin
      acc = bus_b.vaild && bus_b.ready;
      @(posedge sys_clk);
      #1;
      if (acc) begin
        d++;
        bus_b.master_data = d;
      end
      if (b_fifo_cnt == 4'd6) break;
    end
    check("t5_fill", b_fifo_cnt, 6);
    #2;
    reset = 1'b0;
    bus_b.vaild = 1'b0;
    #1;
    check("t5_async_ready", bus_b.ready, 0);
    check("t5_async_rx_data", b_rx_data, 0);
    check("t5_async_rx_vld", b_rx_vld, 0);
    check("t5_async_rx_cnt", b_rx_cnt, 0);
    check("t5_async_fifo_cnt", b_fifo_cnt, 0);
    check("t5_async_seq_err", b_seq_err, 0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b1;
    bus_b.vaild = 1'b1;
    bus_b.master_data = 8'd77;
    for (int n = 0; n < 20; n++) begin
      acc = bus_b.vaild && bus_b.ready;
      @(posedge sys_clk);
      #1;
      if (acc) bus_b.vaild = 1'b0;
      if (b_rx_vld) break;
    end
    check("t5_first_vld", b_rx_vld, 1);
    check("t5_first_data", b_rx_data, 77);
    check("t5_rx_cnt", b_rx_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
